// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with run-time pattern reload,
// selectable overlap and a saturating match counter.
module seq_detect_param #(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PATTERN = 4'b1110,
    parameter int                 CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Din,
    input  logic             Overlap,
    input  logic             Cfg_load,
    input  logic [PAT_W-1:0] Cfg_pat,
    input  logic             Cnt_clr,
    output logic             Dout,
    output logic [CNT_W-1:0] Match_cnt
);

    localparam int               FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

    state_t              r_state;
    logic [PAT_W-1:0]    r_pat;
    logic [PAT_W-1:0]    r_hist;
    logic [FILL_W-1:0]   r_fill;
    logic                r_dout;
    logic [CNT_W-1:0]    r_cnt;

    logic [PAT_W-1:0]    w_hist_next;
    logic [FILL_W-1:0]   w_fill_next;
    logic                w_match;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_hist_next = {r_hist[PAT_W-2:0], Din};
        w_fill_next = r_fill + 1'b1;
        if (r_state == HUNT) begin
            w_fill_next = FILL_FULL;
        end
        w_match = En & ~Cfg_load & (w_fill_next == FILL_FULL) & (w_hist_next == r_pat);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pat   <= PATTERN;
            r_hist  <= '0;
            r_fill  <= '0;
            r_state <= IDLE;
            r_dout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_dout <= w_match;

            // A clear coinciding with a match still counts that match.
            if (Cnt_clr) begin
                r_cnt <= w_match ? CNT_W'(1) : '0;
            end else if (w_match && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (Cfg_load) begin
                r_pat   <= Cfg_pat;
                r_hist  <= '0;
                r_fill  <= '0;
                r_state <= IDLE;
            end else if (En) begin
                if (w_match && !Overlap) begin
                    r_hist  <= '0;
                    r_fill  <= '0;
                    r_state <= IDLE;
                end else begin
                    r_hist  <= w_hist_next;
                    r_fill  <= w_fill_next;
                    r_state <= (w_fill_next == FILL_FULL) ? HUNT : FILL;
                end
            end
        end
    end

    assign Dout      = r_dout;
    assign Match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: two instances (8-bit and 2-bit counters) share
// stimulus; expected pulses come from vector tables, counts from a tally.
module tb_seq_detect_param;

    typedef struct {
        logic       rst;
        logic       en;
        logic       din;
        logic       ovl;
        logic       load;
        logic [3:0] pat;
        logic       clr;
        logic       exp_dout;
    } vec_t;

    typedef struct {
        logic       dout;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, en, din, ovl, load, clr;
    logic [3:0] pat;
    logic       dout8, dout2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int   checks = 0;
    int   errors = 0;
    logic [7:0] m_c8 = '0;
    logic [1:0] m_c2 = '0;
    exp_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1110), .CNT_W(8)) u_dut8 (
        .Clk(clk), .Reset(reset), .En(en), .Din(din), .Overlap(ovl),
        .Cfg_load(load), .Cfg_pat(pat), .Cnt_clr(clr),
        .Dout(dout8), .Match_cnt(cnt8)
    );

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1110), .CNT_W(2)) u_dut2 (
        .Clk(clk), .Reset(reset), .En(en), .Din(din), .Overlap(ovl),
        .Cfg_load(load), .Cfg_pat(pat), .Cnt_clr(clr),
        .Dout(dout2), .Match_cnt(cnt2)
    );

    function automatic vec_t mk(logic r, logic e, logic d, logic o, logic l,
                                logic [3:0] p, logic c, logic x);
        vec_t v;
        v.rst = r; v.en = e; v.din = d; v.ovl = o; v.load = l;
        v.pat = p; v.clr = c; v.exp_dout = x;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, push the expectation, then pop and compare after the edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        reset = v.rst; en = v.en; din = v.din; ovl = v.ovl;
        load = v.load; pat = v.pat; clr = v.clr;
        if (v.rst) begin
            m_c8 = '0; m_c2 = '0;
        end else if (v.clr) begin
            m_c8 = v.exp_dout ? 8'd1 : 8'd0;
            m_c2 = v.exp_dout ? 2'd1 : 2'd0;
        end else if (v.exp_dout) begin
            if (m_c8 != 8'hff) m_c8 = m_c8 + 8'd1;
            if (m_c2 != 2'd3)  m_c2 = m_c2 + 2'd1;
        end
        e.dout = v.exp_dout; e.c8 = m_c8; e.c2 = m_c2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " dout8"}, {7'd0, dout8}, {7'd0, e.dout});
            check({tag, " dout2"}, {7'd0, dout2}, {7'd0, e.dout});
            check({tag, " cnt8"},  cnt8, e.c8);
            check({tag, " cnt2"},  {6'd0, cnt2}, {6'd0, e.c2});
        end
    endtask

    task automatic bit_in(input logic d, input logic o, input logic x, input string tag);
        apply(mk(1'b0, 1'b1, d, o, 1'b0, 4'h0, 1'b0, x), tag);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; din = 1'b0; ovl = 1'b1;
        load = 1'b0; pat = 4'h0; clr = 1'b0;

        // reset state
        vecs.push_back(mk(1, 0, 0, 1, 0, 4'h0, 0, 0));
        // default pattern, overlap: two back-to-back matches, then En low drops Dout
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'h0, 0, 0));
        // 1010 with overlap: pulses after bits 4 and 6
        vecs.push_back(mk(1, 0, 0, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 4'hA, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0, 1));
        // 1010 without overlap: pulse after bit 4 only
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'hA, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'h0, 0, 0));
        // En gaps inside a default-pattern match
        vecs.push_back(mk(1, 0, 0, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'h0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Cfg_load discards its own Din bit (1110 would otherwise match the old pattern)
        apply(mk(1, 0, 0, 1, 0, 4'h0, 0, 0), "ld_rst");
        bit_in(1, 1, 0, "ld_a");
        bit_in(1, 1, 0, "ld_b");
        bit_in(1, 1, 0, "ld_c");
        apply(mk(0, 1, 0, 1, 1, 4'h6, 0, 0), "ld_load");
        bit_in(0, 1, 0, "ld_0");
        bit_in(1, 1, 0, "ld_1");
        bit_in(1, 1, 0, "ld_2");
        bit_in(0, 1, 1, "ld_3");

        // counter saturation (2-bit instance) then clear coincident with a match
        apply(mk(1, 0, 0, 1, 0, 4'h0, 0, 0), "sat_rst");
        for (int m = 0; m < 5; m++) begin
            bit_in(1, 1, 0, $sformatf("sat%0d_a", m));
            bit_in(1, 1, 0, $sformatf("sat%0d_b", m));
            bit_in(1, 1, 0, $sformatf("sat%0d_c", m));
            bit_in(0, 1, 1, $sformatf("sat%0d_d", m));
        end
        bit_in(1, 1, 0, "clr_a");
        bit_in(1, 1, 0, "clr_b");
        bit_in(1, 1, 0, "clr_c");
        apply(mk(0, 1, 0, 1, 0, 4'h0, 1, 1), "clr_match");
        apply(mk(0, 1, 1, 1, 0, 4'h0, 1, 0), "clr_only");

        // reset mid-sequence loses the partial history
        bit_in(1, 1, 0, "mid_a");
        bit_in(1, 1, 0, "mid_b");
        bit_in(1, 1, 0, "mid_c");
        apply(mk(1, 1, 1, 1, 0, 4'h0, 0, 0), "mid_rst");
        bit_in(0, 1, 0, "mid_0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial sequence detector. Successor to the fixed 4-bit "1110" Moore detector.
- Pattern width and pattern value are parameters. The pattern can also be reloaded at run time.
- Overlap or non-overlap detection is selectable. Input bits are qualified by a sample enable. A saturating match counter is added.
- Sits between a serial bit source and downstream control logic. Its output is one registered pulse per detected match.

Parameters:
- PAT_W, 4, pattern length in bits (legal range 2..16).
- PATTERN, 4'b1110, reset/default pattern; MSB is the oldest bit received.
- CNT_W, 8, width of the match counter.

Ports:
- Clk  in  1  clock, rising-edge active.
- Reset  in  1  synchronous, active-high reset.
- En  in  1  Din valid this cycle; when low, Din is ignored.
- Din  in  1  serial data bit.
- Overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- Cfg_load  in  1  load Cfg_pat into the pattern register.
- Cfg_pat  in  PAT_W  new pattern, MSB oldest.
- Cnt_clr  in  1  clear the match counter.
- Dout  out  1  registered match pulse.
- Match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Interface (already decided): one clock, Clk; reset Reset is synchronous and active-high.
- Reset (sampled at a Clk rising edge):
  - pattern register <= PATTERN; history <= 0; fill <= 0; state <= IDLE.
  - Dout <= 0; Match_cnt <= 0.
  - Reset overrides all other inputs.
- Internal registers:
  - pat[PAT_W-1:0]: the pattern.
  - hist[PAT_W-1:0]: shift register of accepted bits.
  - fill: count of accepted bits, saturating at PAT_W.
- FSM states:
  - IDLE: fill = 0.
  - FILL: 0 < fill < PAT_W.
  - HUNT: fill = PAT_W, history is valid.
- Transitions on an accepted bit (En=1, Cfg_load=0):
  - IDLE -> FILL.
  - FILL -> HUNT when fill reaches PAT_W.
  - HUNT -> HUNT on no match, or on a match with Overlap=1.
  - HUNT -> IDLE on a match with Overlap=0: fill and hist cleared, so the next match needs PAT_W fresh bits.
  - When PAT_W bits are supplied starting from IDLE, the FSM enters HUNT on the last of them.
- Match condition:
  - hist_next = {hist[PAT_W-2:0], Din}.
  - match = En & ~Cfg_load & (fill_next == PAT_W) & (hist_next == pat).
- Output timing (Moore-style, one-edge latency):
  - Dout <= match at the same edge that samples the final pattern bit.
  - Dout is high for exactly one cycle per match.
  - Dout = 0 in any cycle following an edge where En=0.
- Match_cnt:
  - Increments on match and saturates at 2^CNT_W - 1.
  - Cnt_clr without a match -> 0.
  - Cnt_clr and a match in the same cycle -> 1.
- Cfg_load:
  - pat <= Cfg_pat; hist <= 0; fill <= 0; state <= IDLE; Dout <= 0.
  - The Din bit in that cycle is discarded even if En=1.
  - Match_cnt is unaffected unless Cnt_clr is also asserted.
- Overlap: may change at any time; it is evaluated only at the edge where a match occurs.
- En=0: hist, fill, state and Match_cnt hold; only Dout drops to 0.
- Reset mid-sequence: partial history is lost; a pattern straddling the reset is not detected.
- Dout and Match_cnt are registered outputs; no combinational path from any input to them.

Test Plan:
- Defaults, En=1, Overlap=1, Din = 1,1,1,0 -> Dout high only in the cycle after the 4th edge; Match_cnt=1. A continued stream 1,1,1,0 -> second pulse 4 cycles later; Match_cnt=2.
- Cfg_load with Cfg_pat=4'b1010, then Din = 1,0,1,0,1,0:
  - Overlap=1 -> pulses after bits 4 and 6; Match_cnt=2.
  - Overlap=0 (repeat after Reset) -> pulse after bit 4 only; Match_cnt=1.
- Default pattern, Din 1,1 with En=1; then 3 cycles with En=0 and Din=0; then 1,0 with En=1 -> exactly one pulse after the final bit; no pulse during the En=0 cycles.
- Feed 1,1,1, then Cfg_load with Cfg_pat=4'b0110 and Din=0, En=1 in that cycle -> no pulse. Then 0,1,1,0 -> pulse after the 4th bit.
- CNT_W=2, five default-pattern matches -> Match_cnt saturates at 3. Then Cnt_clr coincident with a match -> Match_cnt=1, Dout=1.
- Din 1,1,1, assert Reset for one cycle, then Din 0 -> no pulse; Match_cnt=0, Dout=0 immediately after the reset edge.
